game_time_counter: RTL and testbench
====================================

# game_time_counter

Elapsed-game-time counter that consumes the slow `time_tik` square wave from the tick divisor and turns each of its rising edges into one elapsed second. The count is kept as four BCD digits (MM:SS, range 00:00–99:59) for the score/time display. The block sits between the tick divisor and the display driver in the time_and_score area. A small state machine sequences it through idle, running and halted phases, controlled by `start` and `game_over`.

## Interface
Parameters:
- `TIME_LIMIT_MIN`, default 5: minutes at which the game times out. Used only with `GAME_TIME_LIMIT_EN`; legal range 1–99.

Ports:
- `clock_25`  in  1  25 MHz system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  game-active level; the same signal that gates the tick divisor.
- `time_tik`  in  1  tick square wave from the divisor. It is synchronous to `clock_25` and held at 0 while `start`=0.
- `game_over`  in  1  level; snake has died.
- `sec_units`  out  4  BCD, 0–9.
- `sec_tens`  out  4  BCD, 0–5.
- `min_units`  out  4  BCD, 0–9.
- `min_tens`  out  4  BCD, 0–9.
- `running`  out  1  high while in RUN.
- `saturated`  out  1  sticky; count reached 99:59.
- `time_up`  out  1  sticky time-limit flag. Tied to 0 when the feature is compiled out.

## Operation
- Edge detect:
  - `tik_d` is a register holding the previous `time_tik`.
  - `tik_rise = time_tik & ~tik_d`.
  - Falling edges are ignored.
- States: IDLE, RUN, HALT.
  - IDLE: all digits are 0 and held there. Go to RUN when `start`=1. The digits clear on that transition.
  - RUN: on `tik_rise`, increment the count.
    - Go to HALT when `game_over`=1.
    - Go to IDLE when `start`=0 (abort).
  - HALT: the count is frozen for display. Go to IDLE when `start`=0. `game_over` returning low does not leave HALT.
- Increment arithmetic: ripple carry through the digits.
  - `sec_units` wraps 9→0 and carries.
  - `sec_tens` wraps 5→0 and carries.
  - `min_units` wraps 9→0 and carries.
  - `min_tens` increments.
- Saturation: at 99:59 a further `tik_rise` does not wrap. The count holds at 99:59 and `saturated` sets. The state stays RUN.
- Priority within one cycle:
  - In RUN: `start`=0, then `game_over`=1, then `tik_rise`.
  - An edge coinciding with abort or `game_over` is not counted.
- `saturated` and `time_up` clear only on reset or on the IDLE→RUN transition.

## Timing
- Reset values:
  - State IDLE.
  - `tik_d`=0.
  - All digits 0.
  - `running`, `saturated` and `time_up` all 0.
- Reset is asynchronous. Asserting it mid-RUN returns the block to IDLE immediately, regardless of tick phase.
- Latency:
  - If `time_tik` is first sampled high at posedge k (with `tik_d`=0), the digits show the new value after posedge k.
  - `running` follows the state register: high the cycle after the IDLE→RUN edge.
- Only one count per tick period, even if `time_tik` stays high for many cycles.
- If `time_tik` is already 1 when entering RUN, it is not counted if `tik_d` is also 1. The divisor guarantees 0 while `start`=0, so in practice the first count is half a tick period after start.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `GAME_TIME_LIMIT_EN`.
- Defined:
  - When the count reaches `TIME_LIMIT_MIN`:00 in RUN, `time_up` sets on that same edge.
  - The state moves to HALT and the count freezes at exactly `TIME_LIMIT_MIN`:00.
  - `game_over` in the same cycle has the same effect; `time_up` still sets.
- Undefined:
  - `time_up` is constant 0.
  - The count runs to the 99:59 saturation.
  - `TIME_LIMIT_MIN` is ignored.

## Structure
- Shared package `game_time_pkg`:
  - State enum (IDLE/RUN/HALT).
  - 4-bit BCD digit typedef.
  - Constants: `SEC_TENS_MAX`=5, `DIGIT_MAX`=9, and the saturation value 99:59.
- Sub-module `bcd_digit_counter`:
  - Parameter `MODULO`.
  - Inputs: `clear`, `inc`, `hold`.
  - Outputs: `digit`, `carry_out`.
  - Instantiated four times in a carry chain.
  - The top level handles the FSM, edge detect, saturation and limit compare.

## Test plan
- Reset with `start`=1 and `time_tik` toggling → all digits 0, `running`=0 while reset=0. Counting resumes from 00:00 after release.
- `start`=1, 61 tick rising edges (each high for 8 cycles) → 01:01. Exactly one increment per edge; no change on falling edges.
- Preload path (run 5999 edges) then 2 more edges → 99:59 held, `saturated`=1, `running` still 1.
- At 00:07, raise `game_over` in the same cycle as a `tik_rise` → HALT, count stays 00:07. Dropping `game_over` keeps 00:07. `start`=0 → IDLE, 00:00.
- At 00:30, drop `start` → IDLE next edge, digits 00:00. Re-raise `start` → counting restarts from 00:00 with the flags cleared.
- With `GAME_TIME_LIMIT_EN`, `TIME_LIMIT_MIN`=1: 60 edges → 01:00, `time_up`=1, state HALT. A further edge leaves 01:00.

Source files
------------

// File: rtl/game_time_pkg.sv
// Shared types and constants for the elapsed-game-time counter (MM:SS in BCD).
package game_time_pkg;

    localparam int unsigned BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    typedef struct packed {
        bcd_t min_tens;
        bcd_t min_units;
        bcd_t sec_tens;
        bcd_t sec_units;
    } game_time_t;

    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t DIGIT_MAX    = 4'd9;

    localparam game_time_t SAT_TIME = '{
        min_tens:  DIGIT_MAX,
        min_units: DIGIT_MAX,
        sec_tens:  SEC_TENS_MAX,
        sec_units: DIGIT_MAX
    };

    // Count value one second before <minutes>:00, i.e. (minutes-1):59.
    function automatic game_time_t limit_pre_time(input int unsigned minutes);
        int unsigned m;
        game_time_t  t;
        m           = minutes - 1;
        t.min_tens  = 4'(m / 10);
        t.min_units = 4'(m % 10);
        t.sec_tens  = SEC_TENS_MAX;
        t.sec_units = DIGIT_MAX;
        return t;
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the carry chain; wraps at MODULO-1 and reports the carry.
module bcd_digit_counter
    import game_time_pkg::*;
#(
    parameter int unsigned MODULO = 10
) (
    input  logic clock_25,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    input  logic hold,
    output bcd_t digit,
    output logic carry_out
);

    localparam bcd_t LAST = 4'(MODULO - 1);

    // Carry ignores hold so the top digit's carry flags an overflow attempt.
    assign carry_out = inc & (digit == LAST);

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            digit <= '0;
        end else if (clear) begin
            digit <= '0;
        end else if (inc && !hold) begin
            digit <= (digit == LAST) ? '0 : digit + 4'd1;
        end
    end

endmodule

// File: rtl/game_time_counter.sv
// Elapsed game time MM:SS from time_tik rising edges, sequenced IDLE/RUN/HALT.
// Optional time limit enabled by defining GAME_TIME_LIMIT_EN.
module game_time_counter
    import game_time_pkg::*;
#(
    parameter int unsigned TIME_LIMIT_MIN = 5
) (
    input  logic clock_25,
    input  logic reset,
    input  logic start,
    input  logic time_tik,
    input  logic game_over,
    output bcd_t sec_units,
    output bcd_t sec_tens,
    output bcd_t min_units,
    output bcd_t min_tens,
    output logic running,
    output logic saturated,
    output logic time_up
);

`ifdef GAME_TIME_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    localparam game_time_t LIMIT_PRE = limit_pre_time(TIME_LIMIT_MIN);

    state_t     state;
    state_t     state_next;
    logic       tik_d;
    game_time_t count;
    logic       tik_rise;
    logic       count_inc;
    logic       limit_hit;
    logic       clear_digits;
    logic       at_sat;
    logic [3:0] carry;

    // Next state and per-cycle digit controls; abort beats game_over beats tick.
    always_comb begin
        state_next = state;
        tik_rise   = time_tik & ~tik_d;
        limit_hit  = 1'b0;
        count_inc  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!start) begin
                    state_next = ST_IDLE;
                end else begin
                    limit_hit = LIMIT_EN && tik_rise && (count == LIMIT_PRE);
                    if (game_over || limit_hit) state_next = ST_HALT;
                    count_inc = tik_rise & (~game_over | limit_hit);
                end
            end
            ST_HALT: begin
                if (!start) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        clear_digits = (state_next == ST_IDLE);
        at_sat       = (count == SAT_TIME);
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Edge-detect register and sticky flags; flags clear on the IDLE->RUN edge.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            tik_d     <= 1'b0;
            running   <= 1'b0;
            saturated <= 1'b0;
            time_up   <= 1'b0;
        end else begin
            tik_d   <= time_tik;
            running <= (state_next == ST_RUN);
            if (state == ST_IDLE && start) begin
                saturated <= 1'b0;
                time_up   <= 1'b0;
            end else begin
                if (carry[3])  saturated <= 1'b1;
                if (limit_hit) time_up   <= 1'b1;
            end
        end
    end

    bcd_digit_counter #(.MODULO(10)) u_sec_units (
        .clock_25 (clock_25),
        .reset    (reset),
        .clear    (clear_digits),
        .inc      (count_inc),
        .hold     (at_sat),
        .digit    (count.sec_units),
        .carry_out(carry[0])
    );

    bcd_digit_counter #(.MODULO(6)) u_sec_tens (
        .clock_25 (clock_25),
        .reset    (reset),
        .clear    (clear_digits),
        .inc      (carry[0]),
        .hold     (at_sat),
        .digit    (count.sec_tens),
        .carry_out(carry[1])
    );

    bcd_digit_counter #(.MODULO(10)) u_min_units (
        .clock_25 (clock_25),
        .reset    (reset),
        .clear    (clear_digits),
        .inc      (carry[1]),
        .hold     (at_sat),
        .digit    (count.min_units),
        .carry_out(carry[2])
    );

    bcd_digit_counter #(.MODULO(10)) u_min_tens (
        .clock_25 (clock_25),
        .reset    (reset),
        .clear    (clear_digits),
        .inc      (carry[2]),
        .hold     (at_sat),
        .digit    (count.min_tens),
        .carry_out(carry[3])
    );

    assign sec_units = count.sec_units;
    assign sec_tens  = count.sec_tens;
    assign min_units = count.min_units;
    assign min_tens  = count.min_tens;

endmodule

// File: tb/tb_game_time_counter.sv
// Scoreboard bench for game_time_counter: seconds-based reference model feeds an expectation queue.
module tb_game_time_counter;

    localparam int unsigned TLIM = 5;
`ifdef GAME_TIME_LIMIT_EN
    localparam bit LIM_EN = 1'b1;
`else
    localparam bit LIM_EN = 1'b0;
`endif

    logic       clock_25 = 1'b0;
    logic       reset;
    logic       start;
    logic       time_tik;
    logic       game_over;
    logic [3:0] sec_units;
    logic [3:0] sec_tens;
    logic [3:0] min_units;
    logic [3:0] min_tens;
    logic       running;
    logic       saturated;
    logic       time_up;

    game_time_counter #(.TIME_LIMIT_MIN(TLIM)) dut (
        .clock_25 (clock_25),
        .reset    (reset),
        .start    (start),
        .time_tik (time_tik),
        .game_over(game_over),
        .sec_units(sec_units),
        .sec_tens (sec_tens),
        .min_units(min_units),
        .min_tens (min_tens),
        .running  (running),
        .saturated(saturated),
        .time_up  (time_up)
    );

    always #20 clock_25 = ~clock_25;

    // Reference model: elapsed seconds as an integer, phase 0=idle 1=run 2=halt.
    int          m_phase;
    int          m_secs;
    bit          m_sat;
    bit          m_tup;
    bit          m_prev;
    logic [18:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          cycle_no = 0;

    function automatic logic [18:0] model_expect();
        return {4'(m_secs / 600), 4'((m_secs / 60) % 10), 4'((m_secs % 60) / 10),
                4'(m_secs % 10), (m_phase == 1), m_sat, m_tup};
    endfunction

    task automatic model_step(input bit r, input bit s, input bit t, input bit g);
        bit rise;
        if (!r) begin
            m_phase = 0; m_secs = 0; m_sat = 0; m_tup = 0; m_prev = 0;
        end else begin
            rise = t && !m_prev;
            case (m_phase)
                0: if (s) begin m_phase = 1; m_sat = 0; m_tup = 0; end
                1: begin
                    if (!s) begin
                        m_phase = 0; m_secs = 0;
                    end else if (LIM_EN && rise && m_secs == int'(TLIM) * 60 - 1) begin
                        m_secs = m_secs + 1; m_tup = 1; m_phase = 2;
                    end else if (g) begin
                        m_phase = 2;
                    end else if (rise) begin
                        if (m_secs == 5999) m_sat = 1;
                        else m_secs = m_secs + 1;
                    end
                end
                default: if (!s) begin m_phase = 0; m_secs = 0; end
            endcase
            m_prev = t;
        end
    endtask

    // Apply one cycle of inputs, queue the expected post-edge outputs, advance.
    task automatic cyc(input bit r, input bit s, input bit t, input bit g);
        reset = r; start = s; time_tik = t; game_over = g;
        model_step(r, s, t, g);
        exp_q.push_back(model_expect());
        @(posedge clock_25);
        #2;
    endtask

    task automatic edges(input int n, input int hi, input int lo);
        int h;
        int l;
        for (int i = 0; i < n; i++) begin
            h = (hi > 0) ? hi : int'($urandom_range(1, 4));
            l = (lo > 0) ? lo : int'($urandom_range(1, 4));
            repeat (h) cyc(1'b1, 1'b1, 1'b1, 1'b0);
            repeat (l) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        end
    endtask

    // Monitor: every edge the DUT presents new registered outputs; compare them.
    always @(posedge clock_25) begin
        logic [18:0] exp_v;
        logic [18:0] act_v;
        #1;
        cycle_no++;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {min_tens, min_units, sec_tens, sec_units, running, saturated, time_up};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL outputs cycle=%0d got mm:ss=%h%h:%h%h run=%b sat=%b tup=%b want mm:ss=%h%h:%h%h run=%b sat=%b tup=%b",
                         cycle_no, act_v[18:15], act_v[14:11], act_v[10:7], act_v[6:3],
                         act_v[2], act_v[1], act_v[0], exp_v[18:15], exp_v[14:11],
                         exp_v[10:7], exp_v[6:3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
    end

    initial begin
        bit s;
        bit t;
        bit g;
        bit r;
        reset = 1'b0; start = 1'b0; time_tik = 1'b0; game_over = 1'b0;
        m_phase = 0; m_secs = 0; m_sat = 0; m_tup = 0; m_prev = 0;
        @(posedge clock_25);
        #2;
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);

        // Run briefly, then assert reset mid-run with start high and tick toggling.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        edges(3, 8, 8);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, i[0], 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        edges(61, 8, 8);

        // Abort, restart, drive to saturation and beyond.
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        edges(5999, 1, 1);
        edges(2, 1, 1);
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0);

        // game_over coincident with a rising tick edge at 00:07.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        edges(7, 2, 2);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        repeat (3) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        edges(3, 2, 2);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);

        // Abort at 00:30 and restart with cleared flags.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        edges(30, 2, 2);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        edges(4, 0, 0);

        // Random phase: irregular ticks, rare aborts, game_over pulses and resets.
        s = 1'b1; t = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 699) != 0);
            if ($urandom_range(0, 249) == 0) s = ~s;
            if (!s) t = 1'b0;
            else if ($urandom_range(0, 2) == 0) t = ~t;
            g = ($urandom_range(0, 149) == 0);
            cyc(r, s, t, g);
        end

        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
